// File: rtl/button_gesture_decoder.sv
// Classifies debounced button presses into single click, double click and long press pulses.
// Optional auto-repeat while held is enabled by defining GESTURE_AUTO_REPEAT_EN.
module button_gesture_decoder #(
  parameter int CLK_FREQ  = 12000000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_db,
  input  logic button_rising,
  input  logic button_falling,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held,
  output logic repeat_pulse
);

  localparam int DIV = CLK_FREQ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PRESSED     = 3'd1;
  localparam logic [2:0] S_WAIT_SECOND = 3'd2;
  localparam logic [2:0] S_PRESSED2    = 3'd3;
  localparam logic [2:0] S_LONG_HELD   = 3'd4;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
  localparam logic [15:0]   DOUBLE_LAST = 16'(DOUBLE_MS - 1);

  logic [2:0]    state, next_state;
  logic [PW-1:0] presc;
  logic [15:0]   ms_cnt;
  logic          ms_tick, long_due, double_due, repeat_due;
  logic          rise, fall, restart;
  logic          single_nxt, double_nxt, long_nxt, repeat_nxt;

  // Timeouts fire on the tick that would make the count reach N, i.e. N*DIV clocks after entry.
  assign ms_tick    = (presc == PRESC_LAST);
  assign long_due   = ms_tick && (ms_cnt >= LONG_LAST);
  assign double_due = ms_tick && (ms_cnt >= DOUBLE_LAST);

`ifdef GESTURE_AUTO_REPEAT_EN
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_MS - 1);
  assign repeat_due = ms_tick && (ms_cnt >= REPEAT_LAST);
`else
  assign repeat_due = 1'b0;
`endif

  // Simultaneous edge pulses cancel each other.
  assign rise = button_rising & ~button_falling;
  assign fall = button_falling & ~button_rising;

  always_comb begin
    next_state = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) next_state = S_PRESSED;
      end
      S_PRESSED: begin
        // A low level without a falling pulse suppresses the long timeout; a falling pulse does not.
        if (long_due && (button_db || button_falling)) begin
          long_nxt   = 1'b1;
          next_state = S_LONG_HELD;
        end else if (fall) begin
          next_state = S_WAIT_SECOND;
        end
      end
      S_WAIT_SECOND: begin
        if (rise) begin
          next_state = S_PRESSED2;
        end else if (double_due) begin
          single_nxt = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_PRESSED2: begin
        if (long_due && (button_db || button_falling)) begin
          long_nxt   = 1'b1;
          next_state = S_LONG_HELD;
        end else if (fall) begin
          double_nxt = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_LONG_HELD: begin
        if (fall || !button_db) begin
          next_state = S_IDLE;
        end else if (repeat_due) begin
          repeat_nxt = 1'b1;
          restart    = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      presc  <= '0;
      ms_cnt <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || restart) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (ms_tick) begin
        presc <= '0;
        if (ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      single_click <= single_nxt;
      double_click <= double_nxt;
      long_press   <= long_nxt;
      held         <= (next_state == S_LONG_HELD);
      repeat_pulse <= repeat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (LONG_MS > 0 && DOUBLE_MS > 0 && REPEAT_MS >= 0 && DIV >= 1)
        else $error("button_gesture_decoder: illegal timing parameters");
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench for button_gesture_decoder with DIV=10, LONG_MS=50, DOUBLE_MS=20, REPEAT_MS=10.
module tb_button_gesture_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button_db = 1'b0;
  logic button_rising = 1'b0;
  logic button_falling = 1'b0;
  logic single_click, double_click, long_press, held, repeat_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected pulse record: {cycle[27:0], {repeat, long, double, single}}.
  logic [31:0] exp_q[$];

  localparam logic [3:0] EV_SINGLE = 4'b0001;
  localparam logic [3:0] EV_DOUBLE = 4'b0010;
  localparam logic [3:0] EV_LONG   = 4'b0100;
  localparam logic [3:0] EV_REPEAT = 4'b1000;

  button_gesture_decoder #(
    .CLK_FREQ(10000), .LONG_MS(50), .DOUBLE_MS(20), .REPEAT_MS(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_db(button_db),
    .button_rising(button_rising), .button_falling(button_falling),
    .single_click(single_click), .double_click(double_click),
    .long_press(long_press), .held(held), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int cyc, input logic [3:0] ev);
    exp_q.push_back({cyc[27:0], ev});
  endtask

  // Cycle c inputs are sampled at edge c; outputs seen after edge c belong to cycle c+1.
  task automatic run(input int p0, input int r0, input int p1, input int r1,
                     input int len, input int hf, input int ht, input int rst_at);
    logic aborted;
    logic [3:0] vec;
    logic [31:0] exp;
    aborted = 1'b0;
    for (int c = 0; c < len; c++) begin
      rst_n = 1'b1;
      if (c == rst_at) aborted = 1'b1;
      if (aborted) begin
        button_rising  = 1'b0;
        button_falling = 1'b0;
        button_db      = 1'b0;
      end else begin
        button_rising  = (c == p0) || (c == p1);
        button_falling = (c == r0) || (c == r1);
        button_db      = (p0 >= 0 && c >= p0 && (r0 < 0 || c < r0)) ||
                         (p1 >= 0 && c >= p1 && (r1 < 0 || c < r1));
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_single", 32'(single_click), 32'd0);
        chk("rst_double", 32'(double_click), 32'd0);
        chk("rst_long",   32'(long_press),   32'd0);
        chk("rst_held",   32'(held),         32'd0);
        chk("rst_repeat", 32'(repeat_pulse), 32'd0);
      end
      @(posedge clk);
      #1;
      vec = {repeat_pulse, long_press, double_click, single_click};
      if (vec != 4'b0000) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("pulse", {28'(c + 1), vec}, exp);
      end
      if ((c + 1 >= hf && c + 1 < ht) != held || c + 1 == hf || c + 1 == ht)
        chk("held", 32'(held), 32'(c + 1 >= hf && c + 1 < ht));
    end
    rst_n = 1'b1;
    chk("leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_single", 32'(single_click), 32'd0);
    chk("reset_double", 32'(double_click), 32'd0);
    chk("reset_long",   32'(long_press),   32'd0);
    chk("reset_held",   32'(held),         32'd0);
    chk("reset_repeat", 32'(repeat_pulse), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat ($urandom_range(3, 1)) begin
      @(posedge clk);
      #1;
    end

    // Single click.
    push_exp(301, EV_SINGLE);
    run(0, 100, -1, -1, 500, 0, 0, -1);

    // Double click.
    push_exp(301, EV_DOUBLE);
    run(0, 100, 200, 300, 700, 0, 0, -1);

    // Long press held until cycle 900.
    push_exp(501, EV_LONG);
`ifdef GESTURE_AUTO_REPEAT_EN
    push_exp(601, EV_REPEAT);
    push_exp(701, EV_REPEAT);
    push_exp(801, EV_REPEAT);
`endif
    run(0, 900, -1, -1, 1200, 501, 901, -1);

    // Second press held into a long press; no double click on release.
    push_exp(701, EV_LONG);
`ifdef GESTURE_AUTO_REPEAT_EN
    push_exp(801, EV_REPEAT);
`endif
    run(0, 100, 200, 850, 1200, 701, 851, -1);

    // Rising and falling together during the gap are ignored.
    push_exp(301, EV_SINGLE);
    run(0, 100, 200, 200, 600, 0, 0, -1);

    // Rising on the gap timeout cycle wins.
    push_exp(401, EV_DOUBLE);
    run(0, 100, 300, 400, 800, 0, 0, -1);

    // Falling on the long timeout cycle: timeout wins, then held drops.
    push_exp(501, EV_LONG);
    run(0, 500, -1, -1, 900, 501, 502, -1);

    // Reset mid-gesture aborts it silently.
    run(0, 100, -1, -1, 600, 0, 0, 150);

    // Normal classification after the abort.
    push_exp(301, EV_SINGLE);
    run(0, 100, -1, -1, 500, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_gesture_decoder.md
Name: button_gesture_decoder

Overview:
- Consumer end of the debounced-button interface: takes the debounced level plus the single-cycle rising and falling edge pulses and classifies each press.
- Classes: single click, double click, long press.
- Emits one-cycle event pulses for application logic, such as LED modes or menu stepping.
- Sits directly downstream of the debouncer, in the same clock domain.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz; DIV = CLK_FREQ/1000 clocks per ms tick, must be ≥1.
- LONG_MS, 1000, hold time in ms that qualifies a long press.
- DOUBLE_MS, 300, maximum release-to-second-press gap in ms for a double click.
- REPEAT_MS, 200, auto-repeat period in ms; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- button_db  input  1  debounced button level, high = pressed.
- button_rising  input  1  one-cycle pulse on debounced press.
- button_falling  input  1  one-cycle pulse on debounced release.
- single_click  output  1  one-cycle pulse: a single short press is confirmed.
- double_click  output  1  one-cycle pulse: two short presses fell within the gap window.
- long_press  output  1  one-cycle pulse: a hold reached LONG_MS.
- held  output  1  level, high while in LONG_HELD.
- repeat_pulse  output  1  one-cycle auto-repeat pulse; constant 0 without the optional feature.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). While rst_n is low:
  - State goes to IDLE.
  - The prescaler and ms counter are cleared.
  - All outputs are 0.
  - Release is asynchronous. The first active edge after release evaluates IDLE.
- Timebase:
  - The prescaler counts 0..DIV-1 and emits ms_tick when it wraps.
  - The ms counter is 16 bits and saturates at 0xFFFF.
  - Both the prescaler and the ms counter clear on every state transition.
  - A timeout of N ms therefore fires exactly N*DIV clocks after state entry.
- Outputs:
  - All outputs are registered.
  - An event pulse is high in the cycle after the triggering input pulse is sampled, or in the cycle after the timeout count is reached.
  - Pulses are exactly 1 cycle wide, with at most one event pulse per cycle.
- States:
  - IDLE:
    - button_rising goes to PRESSED.
    - button_falling is ignored.
  - PRESSED:
    - button_falling before LONG_MS goes to WAIT_SECOND.
    - Reaching LONG_MS with button_db high pulses long_press and goes to LONG_HELD.
  - WAIT_SECOND:
    - button_rising before DOUBLE_MS goes to PRESSED2.
    - Reaching DOUBLE_MS pulses single_click and goes to IDLE.
  - PRESSED2:
    - button_falling before LONG_MS pulses double_click and goes to IDLE.
    - Reaching LONG_MS pulses long_press and goes to LONG_HELD; the double click is discarded.
  - LONG_HELD:
    - held = 1.
    - button_falling goes to IDLE with no click pulse.
    - If button_db is sampled low without a falling pulse, the block also goes to IDLE (recovery).
- Boundary conditions:
  - button_rising and button_falling in the same cycle: both ignored, state unchanged.
  - A falling pulse in the same cycle the LONG_MS timeout fires: the timeout wins (long_press).
  - A rising pulse in the same cycle the DOUBLE_MS timeout fires: the rising wins (PRESSED2, no single_click).
  - button_db low while in PRESSED or PRESSED2 with no falling pulse: the long-press timeout is suppressed; the state holds until button_falling.
  - rst_n asserted mid-gesture: the gesture is aborted with no pulse.
  - LONG_MS or DOUBLE_MS = 0 is illegal; flagged by a simulation-only assertion.

Optional Feature:
- Macro: GESTURE_AUTO_REPEAT_EN.
- Defined:
  - In LONG_HELD, repeat_pulse fires every REPEAT_MS*DIV clocks, counted from LONG_HELD entry.
  - The first repeat occurs REPEAT_MS after long_press.
  - The prescaler and ms counter restart after each repeat.
  - Repeating stops on exit from LONG_HELD.
- Undefined:
  - repeat_pulse is tied to 0.
  - No repeat counter logic is synthesized.

Test Plan:
All cases use CLK_FREQ=10000 (DIV=10), LONG_MS=50, DOUBLE_MS=20, REPEAT_MS=10.
1. Rising at cycle 0, falling at cycle 100 -> single_click high exactly at cycle 100+200+1 = 301; no other pulses.
2. Rising at cycle 0, falling at 100, rising at 200, falling at 300 -> double_click at cycle 301; no single_click.
3. Rising at cycle 0, button_db held high -> long_press at cycle 501 and held=1 from 501; falling at 900 -> held=0 at 901; no click pulses.
4. Rising at cycle 0, falling at 100, rising at 200, then held -> long_press at cycle 701; no double_click after release.
5. rst_n pulsed low at cycle 150 of the scenario 1 gesture -> all outputs 0 and no single_click ever emitted; a new press after reset classifies normally.
6. GESTURE_AUTO_REPEAT_EN defined, scenario 3 -> repeat_pulse at cycles 601, 701, 801 and none after the falling at 900; without the macro, repeat_pulse stays 0 throughout.
